// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller and its datapath.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full control word driven to the datapath each cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_out.sv
// State-to-control decode. Pure Moore decode except the FETCH IR/PC write,
// which only fires in the cycle memory actually returns the instruction.
// i_active low forces every control to 0 so nothing strobes while in reset.
module multicycle_control_out
  import multicycle_control_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic       i_active,
  output ctrl_t      o_ctrl
);

  // Decode current state into the control word; unencoded states emit all zeros.
  always_comb begin
    o_ctrl = '0;
    if (i_active) begin
      case (i_state)
        S_FETCH: begin
          o_ctrl.mem_read  = 1'b1;
          o_ctrl.alu_src_b = SRCB_FOUR;
          o_ctrl.alu_op    = ALUOP_ADD;
          o_ctrl.pc_source = PCSRC_ALU;
          o_ctrl.ir_write  = i_mem_ready;
          o_ctrl.pc_write  = i_mem_ready;
        end
        S_DECODE: begin
          o_ctrl.alu_src_b = SRCB_IMM_SH2;
          o_ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMADR: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SRCB_IMM;
          o_ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMRD: begin
          o_ctrl.mem_read = 1'b1;
          o_ctrl.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          o_ctrl.mem_write = 1'b1;
          o_ctrl.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SRCB_REGB;
          o_ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_RWB: begin
          o_ctrl.reg_write = 1'b1;
          o_ctrl.reg_dst   = 1'b1;
        end
        S_BEQ: begin
          o_ctrl.alu_src_a     = 1'b1;
          o_ctrl.alu_src_b     = SRCB_REGB;
          o_ctrl.alu_op        = ALUOP_SUB;
          o_ctrl.pc_write_cond = 1'b1;
          o_ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          o_ctrl.pc_write  = 1'b1;
          o_ctrl.pc_source = PCSRC_JUMP;
        end
        S_TRAP: begin
          o_ctrl.illegal = 1'b1;
        end
        default: o_ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: state register, opcode latch and next-state logic.
//
// state  | meaning
// FETCH  | read instruction, PC+4; waits on MemReady
// DECODE | latch opcode, compute branch target
// MEMADR | compute lw/sw address
// MEMRD  | load data read; waits on MemReady
// MEMWB  | write loaded data to register file
// MEMWR  | store data write; waits on MemReady
// EXEC   | R-type ALU operation
// RWB    | write ALU result to rd
// BEQ    | compare and conditionally branch
// JUMP   | load jump target into PC
// TRAP   | unsupported opcode, held until reset
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [5:0] OPCODE,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State,
  output logic       Illegal
);

  // Kept as a raw 4-bit register so unencoded values 11-15 are representable
  // and recover cleanly.
  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [5:0] r_opcode;
  ctrl_t      w_ctrl;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Opcode is captured in DECODE so MEMADR steers on a stable copy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 r_opcode <= 6'b000000;
    else if (r_state == S_DECODE) r_opcode <= OPCODE;
  end

  // Next-state logic; MemReady only matters in the three memory-wait states.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OPCODE)
          OP_R:         w_next_state = S_EXEC;
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR: w_next_state = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next_state = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next_state = S_FETCH;
      S_MEMWR:  w_next_state = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next_state = S_RWB;
      S_RWB:    w_next_state = S_FETCH;
      S_BEQ:    w_next_state = S_FETCH;
      S_JUMP:   w_next_state = S_FETCH;
      S_TRAP:   w_next_state = S_TRAP;
      default:  w_next_state = S_FETCH;
    endcase
  end

  multicycle_control_out u_out (
    .i_state     (r_state),
    .i_mem_ready (MemReady),
    .i_active    (RST_N),
    .o_ctrl      (w_ctrl)
  );

  // Fan the control word out to the named datapath controls.
  always_comb begin
    PCWrite     = w_ctrl.pc_write;
    PCWriteCond = w_ctrl.pc_write_cond;
    IorD        = w_ctrl.i_or_d;
    MemRead     = w_ctrl.mem_read;
    MemWrite    = w_ctrl.mem_write;
    IRWrite     = w_ctrl.ir_write;
    MemToReg    = w_ctrl.mem_to_reg;
    RegDst      = w_ctrl.reg_dst;
    RegWrite    = w_ctrl.reg_write;
    ALUSrcA     = w_ctrl.alu_src_a;
    ALUSrcB     = w_ctrl.alu_src_b;
    ALUOp       = w_ctrl.alu_op;
    PCSource    = w_ctrl.pc_source;
    Illegal     = w_ctrl.illegal;
    State       = r_state;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock domain; reset is asynchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 OPCODE  input  6  instruction[31:26] from the instruction register, valid from DECODE onward.
REQ-005 MemReady  input  1  memory completes the current read/write this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  output  1 each  PC, memory and IR controls.
REQ-007 MemToReg, RegDst, RegWrite, ALUSrcA  output  1 each  register-file and ALU-A controls.
REQ-008 ALUSrcB  output  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-009 ALUOp  output  3  000=add, 001=sub, 010=decode funct.
REQ-010 PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-011 State  output  4  current state encoding, for debug.
REQ-012 Illegal  output  1  unsupported opcode trapped.

Function
REQ-013 SHALL be an FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, TRAP=10.
REQ-014 Outputs not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=1 and PCWrite=1 only while MemReady=1; next DECODE when MemReady=1, else stay.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. OPCODE latches into an internal register. Next state: 000000->EXEC; 100011 or 101011->MEMADR; 000100->BEQ; 000010->JUMP; other->TRAP.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next MEMRD if the latched opcode is lw, else MEMWR.
REQ-018 MEMRD: MemRead=1, IorD=1. Stay until MemReady=1, then MEMWB.
REQ-019 MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Next FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1. Stay until MemReady=1, then FETCH.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next RWB.
REQ-022 RWB: RegWrite=1, RegDst=1, MemToReg=0. Next FETCH.
REQ-023 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. Next FETCH.
REQ-024 JUMP: PCWrite=1, PCSource=10. Next FETCH.
REQ-025 TRAP: Illegal=1; SHALL hold until reset.
REQ-026 Latency without wait states, in cycles: R=4, lw=5, sw=4, beq=3, j=3. Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
REQ-027 While waiting, MemRead/MemWrite and IorD SHALL stay asserted and stable.
REQ-028 MemReady SHALL be ignored in all states other than FETCH, MEMRD and MEMWR.
REQ-029 An unencoded state value (11-15) SHALL go to FETCH on the next edge.
REQ-030 Outputs SHALL be Moore functions of state, except IRWrite and PCWrite in FETCH, which are gated by MemReady.

Reset
REQ-031 With RST_N=0, the FSM SHALL enter FETCH immediately, asynchronously, and the latched opcode SHALL clear to 000000.
REQ-032 Reset mid-instruction, including during a wait state or TRAP, SHALL abandon that instruction; no write strobe SHALL assert while RST_N=0.
REQ-033 The first FETCH after reset release SHALL begin on the first rising CLK with RST_N=1.

Structure
REQ-034 State encodings, opcode constants (R, LW, SW, BEQ, J) and ALUOp/ALUSrcB/PCSource encodings SHALL live in a shared include/package, also used by the datapath.
REQ-035 The state-to-output decode SHALL be a combinational sub-module, multicycle_control_out, with the state register and next-state logic in the top.

Verification
REQ-036 Reset pulse during MEMRD -> State=0 asynchronously, all strobes 0; after release, FETCH with MemRead=1.
REQ-037 OPCODE=000000, MemReady always 1 -> states 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7.
REQ-038 OPCODE=100011, MemReady low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; MemRead and IorD held at 1 through all MEMRD cycles.
REQ-039 OPCODE=101011, MemReady=0 for 3 cycles in FETCH -> IRWrite/PCWrite stay 0 until MemReady=1; then states 1,2,5,0 with MemWrite=1 in 5.
REQ-040 OPCODE=000100, then 000010 -> BEQ asserts PCWriteCond=1, ALUOp=001, PCSource=01; JUMP asserts PCWrite=1, PCSource=10; each returns to FETCH.
REQ-041 OPCODE=111111 -> TRAP, Illegal=1 held for 10 cycles regardless of MemReady; cleared only by RST_N=0.
